// File: rtl/instr_encoder_loader.sv
// Packs symbolic RV32I ops into instruction words, queues them, and writes them to sequential memory words.
// Optional macro IMM_RANGE_CHECK_EN rejects immediates that do not fit their instruction format.
module instr_encoder_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  output logic                  mem_we,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  err_illegal,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  halted
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [6:0]            F7_ALT    = 7'b0100000;

  typedef enum logic [1:0] {IDLE, WRITE, HALT} state_e;
  typedef enum logic [2:0] {K_BAD, K_R, K_I, K_SH, K_LW, K_SW, K_B, K_LUI} kind_e;

  state_e            state, state_nxt;
  kind_e             kind;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [31:0]       enc_word;
  logic              imm_ok;
  logic              rst_done;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              accept, push, pop, bad;

  // Op class and function fields
  always_comb begin
    kind = K_BAD;
    f3   = 3'd0;
    f7   = 7'd0;
    case (in_op)
      5'd0:  kind = K_R;
      5'd1:  begin kind = K_R;  f7 = F7_ALT; end
      5'd2:  kind = K_I;
      5'd3:  kind = K_LUI;
      5'd4:  begin kind = K_R;  f3 = 3'd1; end
      5'd5:  begin kind = K_SH; f3 = 3'd1; end
      5'd6:  begin kind = K_R;  f3 = 3'd5; end
      5'd7:  begin kind = K_SH; f3 = 3'd5; end
      5'd8:  begin kind = K_R;  f3 = 3'd5; f7 = F7_ALT; end
      5'd9:  begin kind = K_SH; f3 = 3'd5; f7 = F7_ALT; end
      5'd10: begin kind = K_R;  f3 = 3'd4; end
      5'd11: begin kind = K_I;  f3 = 3'd4; end
      5'd12: begin kind = K_R;  f3 = 3'd6; end
      5'd13: begin kind = K_I;  f3 = 3'd6; end
      5'd14: begin kind = K_R;  f3 = 3'd7; end
      5'd15: begin kind = K_I;  f3 = 3'd7; end
      5'd16: begin kind = K_R;  f3 = 3'd2; end
      5'd17: begin kind = K_I;  f3 = 3'd2; end
      5'd18: begin kind = K_R;  f3 = 3'd3; end
      5'd19: begin kind = K_I;  f3 = 3'd3; end
      5'd20: begin kind = K_LW; f3 = 3'd2; end
      5'd21: begin kind = K_SW; f3 = 3'd2; end
      5'd22: begin kind = K_B;  f3 = 3'd0; end
      5'd23: begin kind = K_B;  f3 = 3'd1; end
      5'd24: begin kind = K_B;  f3 = 3'd4; end
      5'd25: begin kind = K_B;  f3 = 3'd5; end
      5'd26: begin kind = K_B;  f3 = 3'd6; end
      5'd27: begin kind = K_B;  f3 = 3'd7; end
      default: kind = K_BAD;
    endcase
  end

  // Field packing
  always_comb begin
    enc_word = '0;
    case (kind)
      K_R:   enc_word = {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
      K_I:   enc_word = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0010011};
      K_SH:  enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, 7'b0010011};
      K_LW:  enc_word = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0000011};
      K_SW:  enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], 7'b0100011};
      K_B:   enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1],
                         in_imm[11], 7'b1100011};
      K_LUI: enc_word = {in_imm[31:12], in_rd, 7'b0110111};
      default: enc_word = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Immediate must be representable in the format without loss
  always_comb begin
    imm_ok = 1'b1;
    case (kind)
      K_I, K_LW, K_SW: imm_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
      K_B:   imm_ok = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
      K_SH:  imm_ok = (in_imm[31:5] == '0);
      K_LUI: imm_ok = (in_imm[11:0] == '0);
      default: imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign in_ready  = rst_done && (count != FULL_CNT) && (state != HALT) && !clear;
  assign accept    = in_valid && in_ready;
  assign push      = accept && (kind != K_BAD) && imm_ok;
  assign bad       = accept && !((kind != K_BAD) && imm_ok);
  assign mem_we    = (state == WRITE);
  assign halted    = (state == HALT);
  assign mem_wdata = mem_we ? fifo_mem[rd_ptr] : '0;
  assign pop       = mem_we && mem_ready && !clear;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (count_nxt != '0) state_nxt = WRITE;
      WRITE: begin
        if (pop && (mem_addr == LAST_ADDR)) state_nxt = HALT;
        else if (count_nxt == '0)           state_nxt = IDLE;
      end
      HALT:  state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // FIFO storage, write address and counters; address saturates at the top word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      mem_addr      <= BASE;
      words_written <= '0;
      err_illegal   <= 1'b0;
      rst_done      <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (clear) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        count         <= '0;
        mem_addr      <= BASE;
        words_written <= '0;
        err_illegal   <= 1'b0;
      end else begin
        if (push) begin
          fifo_mem[wr_ptr] <= enc_word;
          wr_ptr           <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr        <= rd_ptr + PTR_W'(1);
          words_written <= words_written + (ADDR_WIDTH + 1)'(1);
          if (mem_addr != LAST_ADDR) mem_addr <= mem_addr + ADDR_WIDTH'(1);
        end
        count       <= count_nxt;
        err_illegal <= bad;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed table, stall/halt/reset sequences, random traffic vs a reference model.
module tb_instr_encoder_loader;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] LAST  = 32'd15;

  logic clk = 1'b0;
  logic rst, clear, in_valid, mem_ready;
  logic in_ready, mem_we, err_illegal, halted;
  logic [4:0] in_op, in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [AW:0] words_written;

  instr_encoder_loader #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .err_illegal(err_illegal), .words_written(words_written), .halted(halted)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Op class per op code: 0 R, 1 I-ALU, 2 shift-imm, 3 LUI, 4 LW, 5 SW, 6 branch
  int kind_tab [28] = '{0,0,1,3,0,2,0,2,0,2,0,1,0,1,0,1,0,1,0,1,4,5,6,6,6,6,6,6};
  int f3_tab   [28] = '{0,0,0,0,1,1,5,5,5,5,4,4,6,6,7,7,2,2,3,3,2,2,0,1,4,5,6,7};

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endfunction

  function automatic logic [31:0] ref_enc(logic [31:0] op, logic [31:0] rd, logic [31:0] rs1,
                                          logic [31:0] rs2, logic [31:0] imm);
    logic [31:0] f3, f7, base;
    f3   = 32'(f3_tab[op]);
    f7   = (op == 1 || op == 8 || op == 9) ? 32'd32 : 32'd0;
    base = (rs1 << 15) | (f3 << 12);
    case (kind_tab[op])
      0: return (f7 << 25) | (rs2 << 20) | base | (rd << 7) | 32'h33;
      1: return ((imm & 32'hFFF) << 20) | base | (rd << 7) | 32'h13;
      2: return (f7 << 25) | ((imm & 32'h1F) << 20) | base | (rd << 7) | 32'h13;
      3: return (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
      4: return ((imm & 32'hFFF) << 20) | base | (rd << 7) | 32'h03;
      5: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | base | ((imm & 32'h1F) << 7) | 32'h23;
      default: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) | base
                      | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
    endcase
  endfunction

  function automatic bit ref_legal(logic [31:0] op, logic [31:0] imm);
    if (op > 27) return 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    begin
      int s;
      s = int'(imm);
      case (kind_tab[op])
        1, 4, 5: return (s >= -2048) && (s <= 2047);
        6:       return (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
        2:       return imm < 32;
        3:       return imm[11:0] == 12'd0;
        default: return 1'b1;
      endcase
    end
`else
    return 1'b1;
`endif
  endfunction

  // Reference model state
  logic [31:0] mq [$];
  logic [31:0] got [$];
  logic [31:0] m_addr, m_words, held_addr, held_data;
  bit m_halted, exp_err, stall_prev, m_up;

  always @(posedge clk or negedge rst) begin
    if (!rst) m_up <= 1'b0;
    else      m_up <= 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
      m_addr = 0; m_words = 0; m_halted = 0; exp_err = 0; stall_prev = 0;
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_in_ready", 32'(in_ready), 0);
    end else begin
      check("err_illegal", 32'(err_illegal), 32'(exp_err));
      check("words_written", 32'(words_written), m_words);
      check("halted", 32'(halted), 32'(m_halted));
      check("mem_we", 32'(mem_we), 32'(mq.size() != 0 && !m_halted));
      check("in_ready", 32'(in_ready), 32'(m_up && !clear && !m_halted && mq.size() < DEPTH));
      if (mem_we) check("mem_addr", 32'(mem_addr), m_addr);
      if (stall_prev && mem_we) begin
        check("stall_addr", 32'(mem_addr), held_addr);
        check("stall_wdata", mem_wdata, held_data);
      end
      stall_prev = mem_we && !mem_ready;
      held_addr  = 32'(mem_addr);
      held_data  = mem_wdata;
      exp_err    = 0;
      if (clear) begin
        mq.delete();
        m_addr = 0; m_words = 0; m_halted = 0; stall_prev = 0;
      end else begin
        if (mem_we && mem_ready && mq.size() > 0) begin
          check("mem_wdata", mem_wdata, mq[0]);
          got.push_back(mem_wdata);
          void'(mq.pop_front());
          m_words++;
          if (m_addr == LAST) m_halted = 1;
          else m_addr++;
        end
        if (in_valid && in_ready) begin
          if (ref_legal(32'(in_op), in_imm))
            mq.push_back(ref_enc(32'(in_op), 32'(in_rd), 32'(in_rs1), 32'(in_rs2), in_imm));
          else
            exp_err = 1;
        end
      end
    end
  end

  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int n = 0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin fail_now("send_timeout"); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      quiet = mem_we ? 0 : quiet + 1;
      if (quiet >= 2) break;
      if (n == 499) fail_now("idle_timeout");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  typedef struct {
    logic [4:0] op, rd, rs1, rs2;
    logic [31:0] imm, exp;
  } vec_t;

  vec_t tbl [9];
  int acc;
  int unsigned base;

  initial begin
    tbl[0] = '{5'd2,  5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093}; // ADDI x1,x0,5
    tbl[1] = '{5'd0,  5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3}; // ADD x3,x1,x2
    tbl[2] = '{5'd1,  5'd3, 5'd1, 5'd2, 32'd0,          32'h402081B3}; // SUB
    tbl[3] = '{5'd9,  5'd4, 5'd1, 5'd0, 32'd3,          32'h4030D213}; // SRAI x4,x1,3
    tbl[4] = '{5'd3,  5'd5, 5'd0, 5'd0, 32'h12345000,   32'h123452B7}; // LUI
    tbl[5] = '{5'd21, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423}; // SW x2,8(x1)
    tbl[6] = '{5'd22, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   32'hFE208EE3}; // BEQ x1,x2,-4
    tbl[7] = '{5'd20, 5'd6, 5'd2, 5'd0, 32'hFFFFFFFC,   32'hFFC12303}; // LW x6,-4(x2)
    tbl[8] = '{5'd23, 5'd0, 5'd1, 5'd2, 32'd8,          32'h00209463}; // BNE x1,x2,8

    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    #12;
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_words", 32'(words_written), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_err", 32'(err_illegal), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Directed encodings
    got.delete();
    for (int i = 0; i < 9; i++) send(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
    wait_idle();
    check("tbl_count", got.size(), 9);
    check("tbl_words", 32'(words_written), 9);
    for (int i = 0; i < 9; i++)
      if (i < got.size()) check($sformatf("tbl_word%0d", i), got[i], tbl[i].exp);

    // Illegal op and out-of-range immediate
    do_clear();
    got.delete();
    send(5'd31, 5'd1, 5'd1, 5'd1, 32'd0);
    @(negedge clk); check("illegal_pulse", 32'(err_illegal), 1);
    @(negedge clk); check("illegal_pulse_end", 32'(err_illegal), 0);
    @(posedge clk); #1;
    send(5'd2, 5'd1, 5'd0, 5'd0, 32'd4096);
    wait_idle();
`ifdef IMM_RANGE_CHECK_EN
    check("range_no_write", got.size(), 0);
`else
    check("trunc_write", got.size(), 1);
    if (got.size() > 0) check("trunc_word", got[0], 32'h00000093);
`endif

    // Backpressure: 6 ops offered while memory stalls for 10 cycles
    do_clear();
    got.delete();
    mem_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      in_op = 5'd2; in_rd = 5'(acc + 1); in_rs1 = 5'd0; in_imm = 32'(acc * 3); in_valid = (acc < 6);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    check("stall_accepts", 32'(acc), DEPTH);
    @(negedge clk); check("stall_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    for (int i = acc; i < 6; i++) send(5'd2, 5'(i + 1), 5'd0, 5'd0, 32'(i * 3));
    wait_idle();
    check("stall_count", got.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) check($sformatf("stall_word%0d", i), got[i], ((i * 3) << 20) | ((i + 1) << 7) | 32'h13);

    // Address exhaustion: 17 ops into a 16-word space
    do_clear();
    got.delete();
    for (int i = 0; i < 17; i++) send(5'd13, 5'(i), 5'(i), 5'd0, 32'(i));
    repeat (4) @(posedge clk); #1;
    @(negedge clk);
    check("halt_flag", 32'(halted), 1);
    check("halt_words", 32'(words_written), 16);
    check("halt_we", 32'(mem_we), 0);
    check("halt_in_ready", 32'(in_ready), 0);
    check("halt_count", got.size(), 16);
    @(posedge clk); #1;
    do_clear();
    @(negedge clk);
    check("clr_halted", 32'(halted), 0);
    check("clr_addr", 32'(mem_addr), 0);
    check("clr_we", 32'(mem_we), 0);
    @(posedge clk); #1;

    // Asynchronous reset during a stalled write
    mem_ready = 1'b0;
    send(5'd0, 5'd7, 5'd8, 5'd9, 32'd0);
    @(negedge clk); check("pre_rst_we", 32'(mem_we), 1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("async_rst_we", 32'(mem_we), 0);
    check("async_rst_ready", 32'(in_ready), 0);
    check("async_rst_addr", 32'(mem_addr), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b1;

    // Random traffic against the model
    base = n_cmp;
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 5'($urandom_range(0, 31));
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_imm    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8191)) - 32'd4096;
      mem_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 79) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clear = 1'b0; mem_ready = 1'b1;
    wait_idle();
    if (n_cmp == base) fail_now("random_no_checks");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
